// File: rtl/program_mem_controller_pkg.sv
// Shared definitions for the program memory controller.
//   state_e         : controller FSM state encoding
//   DefaultAddrBits : default program memory address width (matches the fetcher)
//   DefaultDataBits : default instruction word width (matches the fetcher)
//   id_bits()       : width of a consumer index, never less than one bit
package program_mem_controller_pkg;

  typedef enum logic [1:0] {
    StIdle        = 2'b00,
    StReadWaiting = 2'b01,
    StRelaying    = 2'b10
  } state_e;

  localparam int unsigned DefaultAddrBits = 8;
  localparam int unsigned DefaultDataBits = 32;

  function automatic int unsigned id_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/program_mem_controller_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request vector, one bit per consumer
//   rr_ptr      : highest-priority index; scan proceeds upward with wrap-around
//   grant_valid : at least one request is present
//   grant_id    : index of the selected requester
module rr_arbiter
  import program_mem_controller_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdBits = id_bits(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdBits-1:0] rr_ptr,
  output logic              grant_valid,
  output logic [IdBits-1:0] grant_id
);

  logic [2*NumReq-1:0] req_dbl;
  logic [2*NumReq-1:0] req_rot;
  int unsigned         sum_idx;

  // Rotating a doubled copy puts rr_ptr at bit 0, so a plain priority scan gives round-robin.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl >> rr_ptr;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    sum_idx     = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!grant_valid && req_rot[k]) begin
        grant_valid = 1'b1;
        sum_idx     = 32'(rr_ptr) + k;
        if (sum_idx >= NumReq) begin
          sum_idx = sum_idx - NumReq;
        end
        grant_id = IdBits'(sum_idx);
      end
    end
  end

endmodule

// File: rtl/program_mem_controller.sv
// Read-only program memory controller. Arbitrates per-core fetch requests round-robin,
// forwards one at a time to the external program memory, and returns the word on the
// granted consumer's registered ready/data lines.
//   clk, reset_n            : clock, asynchronous active-low reset
//   consumer_read_valid     : per-consumer request, held until ready is seen
//   consumer_read_address   : packed per-consumer addresses
//   consumer_read_ready     : per-consumer completion (registered, at most one high)
//   consumer_read_data      : packed per-consumer instruction words (registered)
//   mem_read_valid/_address : registered request to external memory
//   mem_read_ready/_data    : memory response strobe and data
module program_mem_controller
  import program_mem_controller_pkg::*;
#(
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned ADDR_BITS     = DefaultAddrBits,
  parameter int unsigned DATA_BITS     = DefaultDataBits
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data
);

  localparam int unsigned IdBits = id_bits(NUM_CONSUMERS);

  state_e                             state_q, state_d;
  logic [IdBits-1:0]                  grant_id_q, grant_id_d;
  logic [IdBits-1:0]                  rr_ptr_q, rr_ptr_d;
  logic                               mem_valid_q, mem_valid_d;
  logic [ADDR_BITS-1:0]               mem_addr_q, mem_addr_d;
  logic [NUM_CONSUMERS-1:0]           ready_q, ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] data_q, data_d;

  logic              arb_valid;
  logic [IdBits-1:0] arb_id;

  rr_arbiter #(
    .NumReq (NUM_CONSUMERS),
    .IdBits (IdBits)
  ) u_rr_arbiter (
    .req         (consumer_read_valid),
    .rr_ptr      (rr_ptr_q),
    .grant_valid (arb_valid),
    .grant_id    (arb_id)
  );

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    ready_d     = ready_q;
    data_d      = data_q;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_id_d  = arb_id;
          mem_valid_d = 1'b1;
          for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
            if (arb_id == IdBits'(i)) begin
              mem_addr_d = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
            end
          end
          state_d = StReadWaiting;
        end
      end

      StReadWaiting: begin
        if (mem_read_ready) begin
          for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
            if (grant_id_q == IdBits'(i)) begin
              data_d[i*DATA_BITS +: DATA_BITS] = mem_read_data;
              ready_d[i]                       = 1'b1;
            end
          end
          mem_valid_d = 1'b0;
          state_d     = StRelaying;
        end
      end

      StRelaying: begin
        // Ready is held until the granted consumer releases valid; a consumer that
        // already dropped valid therefore sees ready for exactly one cycle.
        for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
          if ((grant_id_q == IdBits'(i)) && !consumer_read_valid[i]) begin
            ready_d[i] = 1'b0;
            rr_ptr_d   = (i == NUM_CONSUMERS - 1) ? '0 : IdBits'(i + 1);
            state_d    = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      ready_q     <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
    end
  end

  assign consumer_read_ready = ready_q;
  assign consumer_read_data  = data_q;
  assign mem_read_valid      = mem_valid_q;
  assign mem_read_address    = mem_addr_q;

endmodule

// File: tb/tb_program_mem_controller.sv
// Self-checking bench for program_mem_controller: a memory model with configurable wait
// states checks request order against an address scoreboard; consumer-side checks cover
// latency, data, ready one-hotness, arbitration order, reset and protocol corner cases.
module tb_program_mem_controller;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      consumer_read_valid;
  logic [N*AW-1:0]   consumer_read_address;
  logic [N-1:0]      consumer_read_ready;
  logic [N*DW-1:0]   consumer_read_data;
  logic              mem_read_valid;
  logic [AW-1:0]     mem_read_address;
  logic              mem_read_ready;
  logic [DW-1:0]     mem_read_data;

  program_mem_controller #(
    .NUM_CONSUMERS (N),
    .ADDR_BITS     (AW),
    .DATA_BITS     (DW)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .consumer_read_valid   (consumer_read_valid),
    .consumer_read_address (consumer_read_address),
    .consumer_read_ready   (consumer_read_ready),
    .consumer_read_data    (consumer_read_data),
    .mem_read_valid        (mem_read_valid),
    .mem_read_address      (mem_read_address),
    .mem_read_ready        (mem_read_ready),
    .mem_read_data         (mem_read_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_array [256];
  logic [AW-1:0] exp_addr_q [$];
  int            mem_waits;
  bit            force_ready;
  int            wait_cnt;
  int            valid_run;
  int            last_valid_run;
  logic [AW-1:0] first_addr;

  typedef struct {
    int          id;
    logic [7:0]  addr;
    int          id_waits;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] addr;
  } req_t;

  vec_t vecs [4];
  req_t pend [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: answers a request after mem_waits stall cycles; the address it sees is
  // compared against the scoreboard of expected grant order.
  initial begin
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
    wait_cnt       = 0;
    valid_run      = 0;
    last_valid_run = 0;
    first_addr     = '0;
    forever begin
      @(negedge clk);
      mem_read_ready = 1'b0;
      if (!reset_n) begin
        wait_cnt  = 0;
        valid_run = 0;
      end else if (mem_read_valid) begin
        if (valid_run == 0) first_addr = mem_read_address;
        else check("mem_addr_stable", 64'(mem_read_address), 64'(first_addr));
        valid_run++;
        if (wait_cnt < mem_waits) begin
          wait_cnt++;
        end else begin
          wait_cnt       = 0;
          last_valid_run = valid_run;
          valid_run      = 0;
          mem_read_ready = 1'b1;
          mem_read_data  = mem_array[mem_read_address];
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected: got request %0h expected none", mem_read_address);
          end else begin
            check("mem_addr_order", 64'(mem_read_address), 64'(exp_addr_q.pop_front()));
          end
        end
      end else begin
        wait_cnt  = 0;
        valid_run = 0;
        if (force_ready) begin
          mem_read_ready = 1'b1;
          mem_read_data  = 32'hBAD0_BAD0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // One consumer, one read; expects ready after exp_lat negedges from the request.
  task automatic single_read(input int id, input logic [7:0] a, input int waits,
                             input logic [31:0] exp_data, input int exp_lat, input string tag);
    int           lat;
    bit           seen;
    logic [N-1:0] exp_rdy;
    mem_waits = waits;
    exp_addr_q.push_back(a);
    consumer_read_address[id*AW +: AW] = a;
    consumer_read_valid[id] = 1'b1;
    lat  = 0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (consumer_read_ready[id]) seen = 1'b1;
    end
    exp_rdy     = '0;
    exp_rdy[id] = 1'b1;
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_data"}, 64'(consumer_read_data[id*DW +: DW]), 64'(exp_data));
    check({tag, "_onehot"}, 64'(consumer_read_ready), 64'(exp_rdy));
    consumer_read_valid[id] = 1'b0;
    @(negedge clk);
    check({tag, "_ready_clear"}, 64'(consumer_read_ready), 64'd0);
  endtask

  // Drives every queued request, re-requesting as soon as a consumer is free again.
  task automatic serve(input int max_cycles, input string tag);
    bit [N-1:0]  busy;
    logic [7:0]  cur [N];
    bit          finished;
    busy     = '0;
    finished = 1'b0;
    for (int i = 0; i < N; i++) cur[i] = '0;
    for (int c = 0; c < max_cycles && !finished; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!busy[i] && !consumer_read_ready[i]) begin
          for (int k = 0; k < pend.size(); k++) begin
            if (pend[k].id == i) begin
              cur[i] = pend[k].addr;
              consumer_read_address[i*AW +: AW] = pend[k].addr;
              consumer_read_valid[i] = 1'b1;
              busy[i] = 1'b1;
              pend.delete(k);
              break;
            end
          end
        end
      end
      @(negedge clk);
      check({tag, "_onehot"}, 64'($countones(consumer_read_ready) <= 1), 64'd1);
      for (int i = 0; i < N; i++) begin
        if (busy[i] && consumer_read_ready[i]) begin
          check({tag, "_data"}, 64'(consumer_read_data[i*DW +: DW]), 64'(mem_array[cur[i]]));
          consumer_read_valid[i] = 1'b0;
          busy[i] = 1'b0;
        end
      end
      if (busy == '0 && pend.size() == 0 && consumer_read_ready == '0) finished = 1'b1;
    end
    check({tag, "_all_served"}, 64'(finished), 64'd1);
    check({tag, "_queue_drained"}, 64'(exp_addr_q.size()), 64'd0);
  endtask

  initial begin
    int  cnt;
    bit  seen;
    for (int a = 0; a < 256; a++) begin
      mem_array[a] = {~8'(a), 8'hA5, 8'(a), 8'h5A};
    end
    mem_array[8'h05] = 32'hDEAD_BEEF;
    mem_array[8'h80] = 32'h1234_5678;
    mem_array[8'h00] = 32'hCAFE_F00D;
    mem_array[8'hFF] = 32'h0BAD_C0DE;
    mem_array[8'h07] = 32'h0700_5A5A;
    mem_array[8'h42] = 32'h4242_0042;
    mem_array[8'h61] = 32'h6161_0061;

    vecs[0] = '{id: 0, addr: 8'h05, id_waits: 0, exp_data: 32'hDEAD_BEEF, exp_lat: 2};
    vecs[1] = '{id: 1, addr: 8'h80, id_waits: 1, exp_data: 32'h1234_5678, exp_lat: 3};
    vecs[2] = '{id: 2, addr: 8'h00, id_waits: 3, exp_data: 32'hCAFE_F00D, exp_lat: 5};
    vecs[3] = '{id: 3, addr: 8'hFF, id_waits: 0, exp_data: 32'h0BAD_C0DE, exp_lat: 2};

    reset_n               = 1'b0;
    consumer_read_valid   = '0;
    consumer_read_address = '0;
    force_ready           = 1'b0;
    mem_waits             = 0;
    repeat (3) @(negedge clk);
    check("rst_mem_valid", 64'(mem_read_valid), 64'd0);
    check("rst_mem_addr", 64'(mem_read_address), 64'd0);
    check("rst_ready", 64'(consumer_read_ready), 64'd0);
    check("rst_data", 64'(consumer_read_data != '0), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table of single reads; ids run 0..3 so rr_ptr ends back at 0.
    for (int v = 0; v < 4; v++) begin
      single_read(vecs[v].id, vecs[v].addr, vecs[v].id_waits, vecs[v].exp_data,
                  vecs[v].exp_lat, $sformatf("vec%0d", v));
    end

    // All four at once: served in index order.
    mem_waits = 0;
    for (int i = 0; i < N; i++) begin
      pend.push_back('{id: i, addr: 8'(8'h10 + i)});
      exp_addr_q.push_back(8'(8'h10 + i));
    end
    serve(100, "all4");

    // Consumer 2 re-requests right after completing while 3 waits: 3 goes first.
    mem_waits = 1;
    pend.push_back('{id: 2, addr: 8'h22});
    pend.push_back('{id: 3, addr: 8'h33});
    pend.push_back('{id: 2, addr: 8'h24});
    exp_addr_q.push_back(8'h22);
    exp_addr_q.push_back(8'h33);
    exp_addr_q.push_back(8'h24);
    serve(100, "rr");

    // Five wait states: request held for six cycles.
    single_read(0, 8'h07, 5, 32'h0700_5A5A, 7, "wait5");
    check("wait5_valid_cycles", 64'(last_valid_run), 64'd6);

    // Spurious memory strobes in IDLE.
    force_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("spur_idle_mem_valid", 64'(mem_read_valid), 64'd0);
      check("spur_idle_ready", 64'(consumer_read_ready), 64'd0);
      check("spur_idle_data0", 64'(consumer_read_data[0 +: DW]), 64'h0700_5A5A);
    end
    force_ready = 1'b0;
    @(negedge clk);

    // Spurious memory strobes in RELAYING while consumer 1 holds valid.
    mem_waits = 0;
    exp_addr_q.push_back(8'h80);
    consumer_read_address[1*AW +: AW] = 8'h80;
    consumer_read_valid[1] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (consumer_read_ready[1]) seen = 1'b1;
    end
    check("spur_rel_seen", 64'(seen), 64'd1);
    force_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("spur_rel_ready", 64'(consumer_read_ready), 64'b0010);
      check("spur_rel_data1", 64'(consumer_read_data[1*DW +: DW]), 64'h1234_5678);
      check("spur_rel_mem_valid", 64'(mem_read_valid), 64'd0);
    end
    force_ready = 1'b0;
    consumer_read_valid[1] = 1'b0;
    @(negedge clk);
    check("spur_rel_clear", 64'(consumer_read_ready), 64'd0);

    // Reset in READ_WAITING: outputs clear asynchronously, the read is dropped.
    mem_waits = 10;
    exp_addr_q.push_back(8'h40);
    consumer_read_address[0 +: AW] = 8'h40;
    consumer_read_valid[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (mem_read_valid) seen = 1'b1;
    end
    check("rstmid_mem_valid_seen", 64'(seen), 64'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_mem_valid", 64'(mem_read_valid), 64'd0);
    check("rstmid_mem_addr", 64'(mem_read_address), 64'd0);
    check("rstmid_ready", 64'(consumer_read_ready), 64'd0);
    check("rstmid_data", 64'(consumer_read_data != '0), 64'd0);
    exp_addr_q.delete();
    consumer_read_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    single_read(1, 8'h42, 0, 32'h4242_0042, 2, "post_rst");

    // Consumer 1 abandons its request before the memory answers.
    mem_waits = 3;
    exp_addr_q.push_back(8'h61);
    consumer_read_address[1*AW +: AW] = 8'h61;
    consumer_read_valid[1] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (mem_read_valid) seen = 1'b1;
    end
    check("drop_mem_valid_seen", 64'(seen), 64'd1);
    consumer_read_valid[1] = 1'b0;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (consumer_read_ready[1]) cnt++;
    end
    check("drop_ready_cycles", 64'(cnt), 64'd1);
    check("drop_data", 64'(consumer_read_data[1*DW +: DW]), 64'h6161_0061);
    check("drop_mem_idle", 64'(mem_read_valid), 64'd0);
    single_read(2, 8'h05, 0, 32'hDEAD_BEEF, 2, "after_drop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_mem_controller.md
# program_mem_controller

Read-only program memory controller that terminates the fetch read protocol. Up to `NUM_CONSUMERS` per-core fetchers issue `valid`/`address` requests; the controller grants one at a time round-robin, forwards the request over a single external program-memory read channel, and returns the instruction word on the granted consumer's `ready`/`data` lines. It sits between the cores' fetchers and the external program memory.

## Interface
- `NUM_CONSUMERS`, 4: number of fetcher channels; ≥1.
- `ADDR_BITS`, 8: program memory address width.
- `DATA_BITS`, 32: instruction word width.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `consumer_read_valid`  in  NUM_CONSUMERS  per-consumer request; held high with stable address until its ready is seen.
- `consumer_read_address`  in  NUM_CONSUMERS*ADDR_BITS  packed; consumer i occupies bits [i*ADDR_BITS +: ADDR_BITS].
- `consumer_read_ready`  out  NUM_CONSUMERS  per-consumer completion, registered.
- `consumer_read_data`  out  NUM_CONSUMERS*DATA_BITS  packed per-consumer instruction word, registered.
- `mem_read_valid`  out  1  request to external memory, registered.
- `mem_read_address`  out  ADDR_BITS  registered; stable while `mem_read_valid` is high.
- `mem_read_ready`  in  1  memory response strobe; data valid in the same cycle.
- `mem_read_data`  in  DATA_BITS  memory read data.

## Operation
- FSM states: IDLE, READ_WAITING, RELAYING. Registers: `state`, `grant_id`, `rr_ptr`.
- IDLE:
  - If any `consumer_read_valid` bit is set, select the first requester found scanning upward from `rr_ptr` with wrap-around.
  - Latch it into `grant_id`, drive `mem_read_valid`<=1 and `mem_read_address`<=that consumer's address, then go to READ_WAITING.
  - If no bit is set, stay in IDLE.
- READ_WAITING:
  - On `mem_read_ready`=1: `consumer_read_data[grant_id]`<=`mem_read_data`, `consumer_read_ready[grant_id]`<=1, `mem_read_valid`<=0, go to RELAYING.
  - Otherwise hold all outputs.
- RELAYING:
  - While `consumer_read_valid[grant_id]`=1, hold `ready` high.
  - When it is sampled low: `consumer_read_ready[grant_id]`<=0, `rr_ptr`<=(`grant_id`+1) mod NUM_CONSUMERS, go to IDLE.
- Only `consumer_read_ready[grant_id]` is ever high. At most one bit of `consumer_read_ready` is high at any time.
- A consumer's data register changes only when that consumer completes. It holds its value otherwise.
- `mem_read_ready` is ignored outside READ_WAITING.
- A consumer that drops valid before its ready arrives is a protocol violation. The granted read still completes: ready is asserted for exactly one cycle, then the FSM returns to IDLE.
- Consumer valid is sampled only in IDLE for arbitration. Address is sampled only on the grant edge.

## Timing
- Reset (async assert, sync release): state=IDLE, `rr_ptr`=0, `grant_id`=0, `mem_read_valid`=0, `mem_read_address`=0, all `consumer_read_ready`=0, all `consumer_read_data`=0.
- Reset mid-transaction aborts the read. The outstanding memory response is dropped.
- Request sampled at edge E:
  - `mem_read_valid` is high after E.
  - With a zero-wait memory (`mem_read_ready` high in the next cycle), consumer ready is high after E+1.
  - Minimum request-to-ready latency is 2 cycles; each memory wait cycle adds 1.
- For a fetcher that drops valid one cycle after seeing ready: ready is high after E+1 and low after E+3, IDLE after E+3, next grant at E+4. Peak throughput is 1 read per 4 cycles.
- Round-robin fairness: a continuously requesting consumer waits at most NUM_CONSUMERS−1 other grants.
- With `NUM_CONSUMERS`=1, `rr_ptr` stays 0.

## Structure
- Shared core package holds:
  - FSM state encodings (IDLE=2'b00, READ_WAITING=2'b01, RELAYING=2'b10).
  - Default `ADDR_BITS`/`DATA_BITS` constants, so they match the fetcher's program memory parameters.
- One sub-module, `rr_arbiter`: combinational; inputs are the request vector and `rr_ptr`; outputs are `grant_valid` and `grant_id` (clog2 width, minimum 1 bit).

## Test plan
- Single request, consumer 0, address 0x05; memory returns 0xDEADBEEF with 0 waits → `mem_read_address`=0x05 after E; `consumer_read_ready[0]` and data=0xDEADBEEF after E+1; ready clears after valid drops.
- All 4 consumers request simultaneously at addresses 0x10–0x13 → memory sees 0x10, 0x11, 0x12, 0x13 in order; each consumer receives its own word; no two ready bits are ever high together.
- Consumer 2 re-requests immediately after completion while 3 is pending; `rr_ptr`=3 → consumer 3 is served before consumer 2.
- Memory with 5 wait cycles → `mem_read_valid` and address stay stable for 6 cycles; spurious `mem_read_ready` pulses in IDLE/RELAYING cause no state change.
- `reset_n` pulsed low while in READ_WAITING → all outputs go to reset values immediately (asynchronous); a subsequent request completes normally.
- Consumer 1 drops valid before memory responds → ready[1] high for exactly 1 cycle, data updated, then IDLE.
